// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding and BCD digit constants.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_mac10.sv
// Combinational multiply-by-ten-and-add step for one BCD digit.
// Flags digits outside 0..9 so the caller can mark the conversion invalid.
module bcd_to_bin_seq_mac10
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0]      acc_in,
  input  logic [DIGIT_W-1:0] digit,
  output logic [AW-1:0]      acc_out,
  output logic               digit_bad
);

  // acc*10 built from two shifts so no multiplier is inferred
  assign acc_out   = (acc_in << 3) + (acc_in << 1) + AW'(digit);
  assign digit_bad = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first,
// with a start/busy/done handshake and a held result.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIGIT_W*NDIG-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BW-1:0]           bin_out,
  output logic                    err
);

  localparam int AW = BW + 4;
  localparam int SW = DIGIT_W * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG);

  state_t          state;
  logic [SW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_next;
  logic            err_int;
  logic            digit_bad;

  bcd_to_bin_seq_mac10 #(
    .AW (AW)
  ) u_mac10 (
    .acc_in    (acc),
    .digit     (shreg[SW-1 -: DIGIT_W]),
    .acc_out   (acc_next),
    .digit_bad (digit_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      acc     <= '0;
      err_int <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // bin_out/err deliberately keep the previous result here
          if (start) begin
            shreg   <= bcd_in;
            acc     <= '0;
            cnt     <= '0;
            err_int <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          if (cnt == CNT_LAST) begin
            bin_out <= err_int ? '0 : acc[BW-1:0];
            err     <= err_int;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            acc   <= acc_next;
            shreg <= shreg << DIGIT_W;
            cnt   <= cnt + CW'(1);
            if (digit_bad) begin
              err_int <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (NDIG=3, BW=10): directed cases,
// random digits (including invalid ones) and a full 000..999 sweep.
module tb_bcd_to_bin_seq;

  localparam int NDIG = 3;
  localparam int BW   = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bin_out;
  logic              err;

  int checks;
  int errors;
  int last_val;
  int last_err;

  bcd_to_bin_seq #(
    .NDIG (NDIG),
    .BW   (BW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal interpretation of the packed digits, written as plain arithmetic.
  function automatic void model(input logic [4*NDIG-1:0] b, output int val, output int bad);
    int d;
    val = 0;
    bad = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 'hF);
      if (d > 9) bad = 1;
      val = val * 10 + d;
    end
    if (bad != 0) val = 0;
    val = val % (1 << BW);
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One full transaction; poke re-asserts start mid-conversion with other data.
  task automatic run_conv(input logic [4*NDIG-1:0] b, input bit poke);
    int ev;
    int ee;
    model(b, ev, ee);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    for (int k = 1; k <= NDIG + 2; k++) begin
      @(negedge clk);
      if (poke && (k == 2 || k == 3)) begin
        start  = 1'b1;
        bcd_in = 12'h999;
      end else begin
        start  = 1'b0;
        bcd_in = 12'($urandom);
      end
      check_val("busy_conv", int'(busy), 1);
      check_val("done_timing", int'(done), (k == NDIG + 2) ? 1 : 0);
      if (k < NDIG + 2) begin
        check_val("bin_held", int'(bin_out), last_val);
        check_val("err_held", int'(err), last_err);
      end else begin
        check_val("bin_out", int'(bin_out), ev);
        check_val("err", int'(err), ee);
      end
    end
    last_val = ev;
    last_err = ee;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("busy_idle", int'(busy), 0);
      check_val("done_idle", int'(done), 0);
    end
    $display("conv bcd=%h bin_out=%0d err=%0d exp=%0d/%0d", b, bin_out, err, ev, ee);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_val = 0;
    last_err = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bcd_in   = '0;
    #1;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_bin", int'(bin_out), 0);
    check_val("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_conv(12'h999, 1'b0);
    run_conv(12'h000, 1'b0);
    run_conv(12'h105, 1'b0);
    run_conv(12'h1A5, 1'b0);
    run_conv(12'h042, 1'b0);
    run_conv(12'h250, 1'b1);

    // start held high: a done every NDIG+3 cycles, re-accepted after each IDLE cycle
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h007;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check_val("held_done", int'(done), (k % 6 == 5) ? 1 : 0);
      check_val("held_busy", int'(busy), (k % 6 == 0) ? 0 : 1);
      if (k % 6 == 5) begin
        check_val("held_bin", int'(bin_out), 7);
        $display("held done k=%0d bin_out=%0d", k, bin_out);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check_val("held_release_busy", int'(busy), 0);
    last_val = 7;
    last_err = 0;

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h888;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_done", int'(done), 0);
    check_val("midrst_bin", int'(bin_out), 0);
    check_val("midrst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("midrst_no_done", int'(done), 0);
    end
    $display("mid-conversion reset bin_out=%0d", bin_out);
    last_val = 0;
    last_err = 0;
    run_conv(12'h321, 1'b0);

    for (int n = 0; n < 150; n++) begin
      run_conv(12'($urandom), ($urandom_range(0, 3) == 0));
    end

    for (int v = 0; v < 1000; v++) begin
      run_conv(to_bcd(v), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
